// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block from pipelined main memory,
// streams words into the data array and writes the tag with the last word.
// Optional macro FILL_CRITICAL_WORD_FIRST_EN starts the fill at the missed word.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] data_array_addr,
    output logic              write_tag_array
);

    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W  = WORD_W + 1;
    localparam int OFF_W  = WORD_W + 1;  // byte-offset bits inside one block

    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  ALL_IDX   = CNT_W'(BLOCK_WORDS);

    if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_block_words
        $error("cache_fill_fsm: BLOCK_WORDS must be a power of two, at least 2");
    end
    if (MEM_LATENCY < 1) begin : g_bad_mem_latency
        $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [WORD_W-1:0] issue_word;
    logic [WORD_W-1:0] recv_word;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    logic [WORD_W-1:0] w0_q, w0_d;

    // Rotation wraps naturally in WORD_W bits, so the fill never leaves the block.
    assign issue_word = w0_q + issue_cnt_q[WORD_W-1:0];
    assign recv_word  = w0_q + recv_cnt_q[WORD_W-1:0];
`else
    assign issue_word = issue_cnt_q[WORD_W-1:0];
    assign recv_word  = recv_cnt_q[WORD_W-1:0];
`endif

    // Base has its offset bits cleared, so OR-ing the offset in cannot carry.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [WORD_W-1:0] word);
        return base | {{(ADDR_W - OFF_W){1'b0}}, word, 1'b0};
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d          = state_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        base_d           = base_q;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        w0_d             = w0_q;
`endif
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        data_array_addr  = '0;
        write_tag_array  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d     = FILL;
                    base_d      = miss_address & BASE_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
                    w0_d        = miss_address[OFF_W-1:1];
`endif
                end
            end

            FILL: begin
                fsm_busy = 1'b1;
                // Requests go out back-to-back; returns are tracked independently.
                if (issue_cnt_q < ALL_IDX) begin
                    mem_read_en    = 1'b1;
                    memory_address = word_addr(base_q, issue_word);
                    issue_cnt_d    = issue_cnt_q + CNT_W'(1);
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    data_array_addr  = word_addr(base_q, recv_word);
                    recv_cnt_d       = recv_cnt_q + CNT_W'(1);
                    if (recv_cnt_q == LAST_IDX) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
            w0_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
            w0_q        <= w0_d;
`endif
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: stimulus pushes expected requests,
// writes, tag pulses and busy edges; a negedge monitor pops and compares.
module tb_cache_fill_fsm;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] data_array_addr;
    logic        write_tag_array;

    always #5 clk = ~clk;

    cache_fill_fsm #(.BLOCK_WORDS(BW), .MEM_LATENCY(4), .ADDR_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .fsm_busy         (fsm_busy),
        .mem_read_en      (mem_read_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .data_array_addr  (data_array_addr),
        .write_tag_array  (write_tag_array)
    );

    typedef struct {
        int          cyc;
        logic [15:0] addr;
    } ev_t;

    typedef struct {
        int cyc;
        bit lvl;
    } busy_ev_t;

    ev_t      req_q[$];
    ev_t      wr_q[$];
    int       tag_q[$];
    busy_ev_t busy_q[$];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    bit prev_busy;

    // Per-test stimulus knobs, indexed by cycle relative to the miss.
    bit          vsched[64];
    int          rst_at;
    int          miss_until;
    int          alt_from;
    int          alt_to;
    logic [15:0] alt_addr;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    localparam logic [15:0] BASIC_ORDER[8] = '{16'h1234, 16'h1236, 16'h1238, 16'h123A,
                                               16'h123C, 16'h123E, 16'h1230, 16'h1232};
`else
    localparam logic [15:0] BASIC_ORDER[8] = '{16'h1230, 16'h1232, 16'h1234, 16'h1236,
                                               16'h1238, 16'h123A, 16'h123C, 16'h123E};
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests++;
        failed++;
        $display("FAIL %s: got 0x%0h, expected no event (cycle %0d)", name, act, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [15:0] blk_addr(input logic [15:0] miss, input int i);
        logic [15:0] base = miss & 16'hFFF0;
        int          w0   = 0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        w0 = int'(miss[3:1]);
`endif
        return base + 16'(2 * ((w0 + i) % BW));
    endfunction

    task automatic exp_req(input int c, input logic [15:0] a);
        ev_t e;
        e.cyc  = c;
        e.addr = a;
        req_q.push_back(e);
    endtask

    task automatic exp_wr(input int c, input logic [15:0] a);
        ev_t e;
        e.cyc  = c;
        e.addr = a;
        wr_q.push_back(e);
    endtask

    task automatic exp_busy(input int c, input bit lvl);
        busy_ev_t b;
        b.cyc = c;
        b.lvl = lvl;
        busy_q.push_back(b);
    endtask

    // A full fill with a 4-cycle memory: requests t0+1..8, returns t0+5..12.
    task automatic expect_normal(input int t0, input int rel0, input logic [15:0] miss);
        for (int i = 0; i < BW; i++) begin
            vsched[rel0 + 5 + i] = 1'b1;
            exp_req(t0 + rel0 + 1 + i, blk_addr(miss, i));
            exp_wr(t0 + rel0 + 5 + i, blk_addr(miss, i));
        end
        tag_q.push_back(t0 + rel0 + 12);
        exp_busy(t0 + rel0 + 1, 1'b1);
        exp_busy(t0 + rel0 + 13, 1'b0);
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) vsched[i] = 1'b0;
        rst_at     = -1;
        miss_until = -1;
        alt_from   = 0;
        alt_to     = 0;
        alt_addr   = 16'h0000;
    endtask

    task automatic drive(input logic [15:0] addr, input int ncyc);
        for (int r = 0; r < ncyc; r++) begin
            rst               = (r == rst_at);
            miss_detected     = (r == 0) || (r <= miss_until);
            miss_address      = (r >= alt_from && r < alt_to) ? alt_addr : addr;
            memory_data_valid = vsched[r];
            tick();
        end
        rst               = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic end_check(input string name);
        check({name, "_reqs_left"}, 32'(req_q.size()), 32'd0);
        check({name, "_writes_left"}, 32'(wr_q.size()), 32'd0);
        check({name, "_tags_left"}, 32'(tag_q.size()), 32'd0);
        check({name, "_busy_left"}, 32'(busy_q.size()), 32'd0);
        req_q.delete();
        wr_q.delete();
        tag_q.delete();
        busy_q.delete();
    endtask

    ev_t      m_ev;
    busy_ev_t m_busy;
    int       m_tag;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_read_en) begin
                if (req_q.size() == 0) unexpected("req", 32'(memory_address));
                else begin
                    m_ev = req_q.pop_front();
                    check("req_cycle", cyc, m_ev.cyc);
                    check("req_addr", 32'(memory_address), 32'(m_ev.addr));
                end
            end else begin
                check("req_addr_quiet", 32'(memory_address), 32'd0);
            end
            if (write_data_array) begin
                if (wr_q.size() == 0) unexpected("write", 32'(data_array_addr));
                else begin
                    m_ev = wr_q.pop_front();
                    check("write_cycle", cyc, m_ev.cyc);
                    check("write_addr", 32'(data_array_addr), 32'(m_ev.addr));
                end
            end
            if (write_tag_array) begin
                if (tag_q.size() == 0) unexpected("tag", cyc);
                else begin
                    m_tag = tag_q.pop_front();
                    check("tag_cycle", cyc, m_tag);
                end
            end
            if (fsm_busy !== prev_busy) begin
                if (busy_q.size() == 0) unexpected("busy_edge", 32'(fsm_busy));
                else begin
                    m_busy = busy_q.pop_front();
                    check("busy_cycle", cyc, m_busy.cyc);
                    check("busy_level", 32'(fsm_busy), 32'(m_busy.lvl));
                end
                prev_busy = fsm_busy;
            end
        end
    end

    initial begin
        int t0;
        int gap[8] = '{5, 7, 8, 11, 12, 13, 20, 21};

        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        clear_sched();

        // Reset for two cycles, then stray returns with no miss.
        tick();
        check("reset_flags", {28'd0, fsm_busy, mem_read_en, write_data_array, write_tag_array}, 32'd0);
        check("reset_addrs", {memory_address, data_array_addr}, 32'd0);
        prev_busy         = 1'b0;
        mon_en            = 1'b1;
        memory_data_valid = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        memory_data_valid = 1'b0;
        tick();
        end_check("reset");

        // Basic fill from 0x1234 with hand-listed address order.
        clear_sched();
        t0 = cyc;
        for (int i = 0; i < BW; i++) begin
            vsched[5 + i] = 1'b1;
            exp_req(t0 + 1 + i, BASIC_ORDER[i]);
            exp_wr(t0 + 5 + i, BASIC_ORDER[i]);
        end
        tag_q.push_back(t0 + 12);
        exp_busy(t0 + 1, 1'b1);
        exp_busy(t0 + 13, 1'b0);
        drive(16'h1234, 14);
        end_check("basic");

        // Miss held throughout, address changes mid-fill; refill starts at 14.
        clear_sched();
        t0         = cyc;
        miss_until = 13;
        alt_from   = 3;
        alt_to     = 11;
        alt_addr   = 16'h4000;
        expect_normal(t0, 0, 16'h1234);
        expect_normal(t0, 13, 16'h1234);
        drive(16'h1234, 27);
        end_check("ignored_miss");

        // Top block with irregular return gaps.
        clear_sched();
        t0 = cyc;
        for (int i = 0; i < BW; i++) exp_req(t0 + 1 + i, blk_addr(16'hFFFA, i));
        for (int k = 0; k < BW; k++) begin
            vsched[gap[k]] = 1'b1;
            exp_wr(t0 + gap[k], blk_addr(16'hFFFA, k));
        end
        tag_q.push_back(t0 + 21);
        exp_busy(t0 + 1, 1'b1);
        exp_busy(t0 + 22, 1'b0);
        drive(16'hFFFA, 23);
        end_check("wrap_gaps");

        // Reset in cycle 6 of a fill of 0x0100; later returns are ignored.
        clear_sched();
        t0     = cyc;
        rst_at = 6;
        for (int i = 5; i <= 12; i++) vsched[i] = 1'b1;
        for (int i = 0; i < 6; i++) exp_req(t0 + 1 + i, 16'h0100 + 16'(2 * i));
        exp_wr(t0 + 5, 16'h0100);
        exp_wr(t0 + 6, 16'h0102);
        exp_busy(t0 + 1, 1'b1);
        exp_busy(t0 + 7, 1'b0);
        drive(16'h0100, 14);
        end_check("reset_mid");

        clear_sched();
        t0 = cyc;
        expect_normal(t0, 0, 16'h0200);
        drive(16'h0200, 14);
        end_check("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
